// File: rtl/hpi_pkg.sv
// Shared state encoding, HPI register selects and default timing for the
// CY7C67200 host-port sequencer.
package hpi_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } hpi_state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int DEF_RST_CYC    = 16;
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_STROBE_CYC = 4;
    localparam int DEF_HOLD_CYC   = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hpi_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last granted requester.
module rr_arb2
    import hpi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       pointer
);

    // With both requesting, the one not served last wins.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            pointer <= grant[1];
        end
    end

endmodule

// File: rtl/hpi_access_ctrl.sv
// HPI sequencer: chip reset pulse, round-robin arbitration between two
// requesters and setup/strobe/hold timed single-word reads and writes.
module hpi_access_ctrl
    import hpi_pkg::*;
#(
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        hpi_rst_n,
    output logic [15:0] hpi_dout,
    output logic        hpi_dout_en,
    input  logic [15:0] hpi_din
);

    localparam int MAX_CYC = max4(RST_CYC, SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    hpi_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cur_write;
    logic [1:0]       grant;
    logic             last_grant;
    logic             accept;
    logic             sel_write;
    logic [1:0]       sel_addr;
    logic [15:0]      sel_wdata;

    // The pointer updates on accept, so it also names the current owner.
    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant),
        .pointer (last_grant)
    );

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign sel_write = grant[1] ? req_write[1]      : req_write[0];
    assign sel_addr  = grant[1] ? req_addr[3:2]     : req_addr[1:0];
    assign sel_wdata = grant[1] ? req_wdata[31:16]  : req_wdata[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RST_HOLD;
            cnt         <= RST_LOAD;
            cur_write   <= 1'b0;
            hpi_rst_n   <= 1'b0;
            hpi_cs_n    <= 1'b1;
            hpi_rd_n    <= 1'b1;
            hpi_wr_n    <= 1'b1;
            hpi_addr    <= 2'd0;
            hpi_dout    <= 16'h0000;
            hpi_dout_en <= 1'b0;
            rsp_valid   <= 2'b00;
            rsp_rdata   <= 16'h0000;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                RST_HOLD: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        hpi_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        state       <= SETUP;
                        cnt         <= SETUP_LOAD;
                        cur_write   <= sel_write;
                        hpi_cs_n    <= 1'b0;
                        hpi_addr    <= sel_addr;
                        hpi_dout    <= sel_write ? sel_wdata : 16'h0000;
                        hpi_dout_en <= sel_write;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state    <= STROBE;
                        cnt      <= STROBE_LOAD;
                        hpi_rd_n <= cur_write;
                        hpi_wr_n <= ~cur_write;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STROBE: begin
                    // Read data is captured while rd_n is still low on the pad.
                    if (cnt == '0) begin
                        state     <= HOLD;
                        cnt       <= HOLD_LOAD;
                        hpi_rd_n  <= 1'b1;
                        hpi_wr_n  <= 1'b1;
                        rsp_valid <= last_grant ? 2'b10 : 2'b01;
                        rsp_rdata <= cur_write ? 16'h0000 : hpi_din;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state       <= IDLE;
                        hpi_cs_n    <= 1'b1;
                        hpi_dout    <= 16'h0000;
                        hpi_dout_en <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state     <= RST_HOLD;
                    cnt       <= RST_LOAD;
                    hpi_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hpi_access_ctrl.md
# hpi_access_ctrl

- Hardware sequencer for the CY7C67200 OTG host-port interface (HPI).
- Two requesters share the 16-bit HPI bus:
  - port 0: CPU-side bridge.
  - port 1: hardware keycode poller.
- Arbitration is round-robin, one transaction at a time.
- Each transaction is one HPI read or write, with programmable setup, strobe and hold timing; read data is returned to the requester.
- The block also drives the chip reset sequence after system reset.

## Interface
Parameters:
- RST_CYC, 16: cycles hpi_rst_n is held low after reset (≥1).
- SETUP_CYC, 2: cycles of cs/addr/data valid before the strobe (≥1).
- STROBE_CYC, 4: cycles rd_n/wr_n is low (≥1).
- HOLD_CYC, 2: cycles cs/addr/data held after the strobe (≥1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request
- req_write  in  2  1 = write, 0 = read
- req_addr  in  4  {port1[1:0], port0[1:0]} HPI register select
- req_wdata  in  32  {port1[15:0], port0[15:0]}
- req_ready  out  2  accept strobe (combinational)
- rsp_valid  out  2  one-cycle completion pulse per requester
- rsp_rdata  out  16  read data, valid while rsp_valid≠0
- hpi_addr  out  2  HPI A[1:0]
- hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n  out  1 each  active-low HPI controls
- hpi_dout  out  16  write data
- hpi_dout_en  out  1  tri-state enable for the top-level data pad
- hpi_din  in  16  read data from the pad

## Operation
States: RST_HOLD → IDLE → SETUP → STROBE → HOLD → IDLE.

- **RST_HOLD**
  - hpi_rst_n=0 for RST_CYC cycles, then the block moves to IDLE.
  - No requests are accepted.
- **IDLE**
  - The arbiter picks a winner among the valid requesters.
  - With both valid, the winner is the requester not granted last. The last-grant pointer resets to 1, so port 0 wins first.
  - req_ready[winner]=1 in that same cycle. The handshake (valid&ready) captures write, addr and wdata.
  - The next state is SETUP.
- **SETUP**
  - hpi_cs_n=0, hpi_addr=captured addr.
  - On a write: hpi_dout=wdata and hpi_dout_en=1.
- **STROBE**
  - As SETUP, plus hpi_rd_n=0 (read) or hpi_wr_n=0 (write).
  - Reads register hpi_din on the last STROBE cycle.
- **HOLD**
  - cs, addr and dout/dout_en are held; rd_n and wr_n are 1.
  - rsp_valid[owner] pulses on the first HOLD cycle. rsp_rdata = sampled data on reads, 0 on writes.
  - After HOLD_CYC cycles the block returns to IDLE.
- A single down-counter (width = clog2 of the largest parameter + 1) times every state.
- req_ready is 0 outside IDLE. A requester holds valid and payload until it sees ready.
- A requester dropping valid before grant is legal and is not serviced.

Reset values of all outputs:
- hpi_cs_n=hpi_rd_n=hpi_wr_n=1, hpi_rst_n=0.
- hpi_addr=0, hpi_dout=0, hpi_dout_en=0.
- req_ready=0, rsp_valid=0, rsp_rdata=0.

## Timing
With defaults (S=2, T=4, H=2), taking the accept edge as cycle 0:

| Cycles | State | Notes |
|---|---|---|
| 1–2 | SETUP | |
| 3–6 | STROBE | hpi_din sampled at the end of cycle 6 |
| 7–8 | HOLD | rsp_valid at cycle 7 |
| 9 | IDLE | earliest next accept |

- Throughput: one transaction per S+T+H+1 cycles.
- All HPI outputs are registered, so strobes are glitch-free.
- rd_n and wr_n are never low together.
- dout_en never overlaps rd_n=0.
- Reset asserted mid-transaction:
  - The next edge forces the reset values and re-enters RST_HOLD.
  - The in-flight transaction is dropped with no rsp_valid.
- Simultaneous valid on both ports in consecutive transactions alternates the grant 0,1,0,1.
- A single active requester is granted on every IDLE.

## Structure
- Shared package hpi_pkg holds:
  - the state enum;
  - HPI register constants: DATA=2'd0, MAILBOX=2'd1, ADDRESS=2'd2, STATUS=3'd3→2'd3;
  - default timing constants.
- Sub-module rr_arb2 is the two-way round-robin arbiter, with:
  - inputs: valid[1:0], advance;
  - outputs: grant one-hot, pointer register.
- The FSM and counter live in the top module.

## Test plan
- **Reset release:** reset for 3 cycles, then no requests → hpi_rst_n low exactly 16 cycles after reset deasserts. All strobes stay high and req_ready stays 0 throughout.
- **Single write:** port 0 writes addr 2'd2, data 16'h1234 → cs_n low cycles 1–8, wr_n low cycles 3–6, dout=16'h1234 with dout_en=1 cycles 1–8, rsp_valid=2'b01 at cycle 7 with rdata=0.
- **Single read:** port 1 reads addr 2'd0 while the bench drives hpi_din=16'hBEEF during STROBE → rd_n low cycles 3–6, dout_en=0, rsp_valid=2'b10 with rsp_rdata=16'hBEEF at cycle 7.
- **Contention:** both ports hold valid for 4 transactions → grants 0,1,0,1, accepts spaced exactly 9 cycles apart.
- **Reset mid-strobe:** reset at cycle 4 of a write → wr_n and cs_n return high the next edge, no rsp_valid, hpi_rst_n=0, RST_HOLD re-run.
- **Parameter sweep:** S=1, T=1, H=1 → rsp_valid at cycle 3, next accept at cycle 4.
